// File: rtl/conv_sequencer.sv
// conv_sequencer: runs a 3x3 "valid" convolution over a row-major 8-bit image
// held in the data RAM.
//
// For each output pixel the block does the following:
//   - issues nine reads,
//   - accumulates pixel*coefficient one cycle behind each read,
//   - scales the sum by an arithmetic right shift,
//   - clamps the result to 0..255,
//   - writes one byte.
// Each output pixel takes 11 cycles: 9 RD, 1 LAST, 1 WR.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, abort        job request (IDLE only) / synchronous cancel
//   img_w, img_h        image size, latched at start (valid range 3..64)
//   k_we, k_idx, k_data kernel tap write port (ignored while busy)
//   mem_*               single data-RAM port; read data returns one cycle later
//   busy, done, err     job running / completion pulse / bad-dimension flag
module conv_sequencer #(
  parameter logic [11:0] IN_BASE  = 12'h000,
  parameter logic [11:0] OUT_BASE = 12'h800,
  parameter int unsigned SHIFT    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [6:0]  img_w,
  input  logic [6:0]  img_h,
  input  logic        k_we,
  input  logic [3:0]  k_idx,
  input  logic [7:0]  k_data,
  output logic [11:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [7:0]  mem_rdata,
  output logic        mem_wr_en,
  output logic [7:0]  mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_LAST = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [6:0]         w_q, w_d, h_q, h_d, r_q, r_d, c_q, c_d;
  logic [3:0]         tap_q, tap_d;
  logic signed [20:0] acc_q, acc_d;
  logic               err_q, err_d;
  logic signed [7:0]  kern_q [9];

  logic busy_w;
  assign busy_w = (state_q == S_RD) || (state_q == S_LAST) || (state_q == S_WR);

  // Split the tap number into kernel row/column without a divider.
  logic [1:0] ti, tj;
  always_comb begin
    ti = 2'd0;
    tj = 2'd0;
    if (tap_q < 4'd3) begin
      tj = tap_q[1:0];
    end else if (tap_q < 4'd6) begin
      ti = 2'd1;
      tj = 2'(tap_q - 4'd3);
    end else begin
      ti = 2'd2;
      tj = 2'(tap_q - 4'd6);
    end
  end

  // Offsets are computed wide and then truncated, so addresses wrap modulo 4096.
  logic [15:0] rd_off, wr_off;
  assign rd_off = ({9'd0, r_q} + {14'd0, ti}) * {9'd0, w_q} + {9'd0, c_q} + {14'd0, tj};
  assign wr_off = {9'd0, r_q} * ({9'd0, w_q} - 16'd2) + {9'd0, c_q};

  // Read data lags the read by one cycle, so this cycle's data belongs to
  // tap_q-1. In LAST it belongs to tap 8.
  logic [3:0]        acc_idx;
  logic signed [7:0] k_sel;
  assign acc_idx = (state_q == S_LAST) ? 4'd8 : tap_q - 4'd1;
  always_comb begin
    k_sel = '0;
    if (acc_idx <= 4'd8) k_sel = kern_q[acc_idx];
  end

  // The pixel is zero-extended so the multiply stays signed-by-signed.
  logic signed [16:0] px_s, k_s, prod;
  assign px_s = {9'd0, mem_rdata};
  assign k_s  = {{9{k_sel[7]}}, k_sel};
  assign prod = px_s * k_s;

  logic acc_en;
  assign acc_en = ((state_q == S_RD) && (tap_q != 4'd0)) || (state_q == S_LAST);

  logic signed [20:0] scaled;
  logic [7:0]         result;
  assign scaled = acc_q >>> SHIFT;
  always_comb begin
    result = scaled[7:0];
    if (scaled < 0)               result = 8'd0;
    else if (scaled > 21'sd255)   result = 8'd255;
  end

  logic row_end, last_px;
  assign row_end = (c_q == w_q - 7'd3);
  assign last_px = row_end && (r_q == h_q - 7'd3);

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    r_d     = r_q;
    c_d     = c_q;
    tap_d   = tap_q;
    acc_d   = acc_q;
    err_d   = err_q;
    if (acc_en) acc_d = acc_q + {{4{prod[16]}}, prod};
    case (state_q)
      S_IDLE: begin
        if (start) begin
          w_d   = img_w;
          h_d   = img_h;
          r_d   = '0;
          c_d   = '0;
          tap_d = '0;
          acc_d = '0;
          if ((img_w < 7'd3) || (img_h < 7'd3)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (tap_q == 4'd8) begin
          tap_d   = '0;
          state_d = S_LAST;
        end else begin
          tap_d = tap_q + 4'd1;
        end
      end
      S_LAST: state_d = S_WR;
      S_WR: begin
        acc_d = '0;
        if (row_end) begin
          c_d = '0;
          r_d = r_q + 7'd1;
        end else begin
          c_d = c_q + 7'd1;
        end
        state_d = last_px ? S_DONE : S_RD;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      h_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      tap_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      r_q     <= r_d;
      c_q     <= c_d;
      tap_q   <= tap_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) kern_q[i] <= '0;
    end else if (k_we && !busy_w && (k_idx <= 4'd8)) begin
      kern_q[k_idx] <= k_data;
    end
  end

  // An abort that arrives during WR must stop the write in that same cycle,
  // so the strobe is gated combinationally.
  assign mem_rd_en = (state_q == S_RD);
  assign mem_wr_en = (state_q == S_WR) && !abort;
  assign mem_addr  = (state_q == S_RD) ? IN_BASE + rd_off[11:0] :
                     (state_q == S_WR) ? OUT_BASE + wr_off[11:0] : 12'd0;
  assign mem_wdata = (state_q == S_WR) ? result : 8'd0;
  assign busy      = busy_w;
  assign done      = (state_q == S_DONE) && !abort;
  assign err       = err_q;

endmodule
